cordic_seq_ctrl: RTL and testbench

CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

---
 rtl/cordic_seq_ctrl.sv | 115 +++++++++++
 tb/tb_cordic_seq_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl.sv
// rtl/cordic_seq_ctrl.sv - CORDIC iteration sequencer: load pulse, shift index walk, hyperbolic repeats, done/err pulses
module cordic_seq_ctrl #(
  parameter int N_ITER = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] coordinate_system_in,
  input  logic       mode_vec,
  output logic       busy,
  output logic       load,
  output logic       iter_en,
  output logic [5:0] shift,
  output logic [1:0] coord_sel,
  output logic       mode_sel,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  localparam logic [1:0] CODE_RSVD = 2'b10;
  localparam logic [1:0] CODE_HYP  = 2'b11;
  localparam logic [5:0] LAST_LC   = 6'(N_ITER - 1);
  localparam logic [5:0] LAST_HYP  = 6'(N_ITER);

  state_t     state;
  logic [5:0] idx;
  logic       rpt;
  logic       hyp;
  logic [5:0] last;
  logic       rpt_due;

  assign hyp  = (coord_sel == CODE_HYP);
  assign last = hyp ? LAST_HYP : LAST_LC;
  // Hyperbolic convergence needs indices 4, 13, 40 executed twice.
  assign rpt_due = hyp && !rpt && (idx == 6'd4 || idx == 6'd13 || idx == 6'd40);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 6'd0;
      rpt       <= 1'b0;
      busy      <= 1'b0;
      load      <= 1'b0;
      iter_en   <= 1'b0;
      shift     <= 6'd0;
      coord_sel <= 2'b00;
      mode_sel  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      if (abort && state != S_IDLE) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        iter_en <= 1'b0;
        shift   <= 6'd0;
        idx     <= 6'd0;
        rpt     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              if (coordinate_system_in == CODE_RSVD) begin
                err <= 1'b1;
              end else begin
                state     <= S_LOAD;
                coord_sel <= coordinate_system_in;
                mode_sel  <= mode_vec;
                busy      <= 1'b1;
                load      <= 1'b1;
                idx       <= 6'd0;
                rpt       <= 1'b0;
              end
            end
          end
          S_LOAD: begin
            state   <= S_ITER;
            iter_en <= 1'b1;
            idx     <= hyp ? 6'd1 : 6'd0;
            shift   <= hyp ? 6'd1 : 6'd0;
          end
          S_ITER: begin
            if (idx == last && !rpt_due) begin
              state   <= S_DONE;
              busy    <= 1'b0;
              iter_en <= 1'b0;
              shift   <= 6'd0;
              idx     <= 6'd0;
              rpt     <= 1'b0;
              done    <= 1'b1;
            end else if (rpt_due) begin
              rpt <= 1'b1;
            end else begin
              idx   <= idx + 6'd1;
              shift <= idx + 6'd1;
              rpt   <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb/tb_cordic_seq_ctrl.sv - directed checks of the CORDIC sequencer at N_ITER=16
module tb_cordic_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] coordinate_system_in;
  logic       mode_vec;
  logic       busy;
  logic       load;
  logic       iter_en;
  logic [5:0] shift;
  logic [1:0] coord_sel;
  logic       mode_sel;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  cordic_seq_ctrl #(.N_ITER(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .coordinate_system_in(coordinate_system_in),
    .mode_vec(mode_vec),
    .busy(busy),
    .load(load),
    .iter_en(iter_en),
    .shift(shift),
    .coord_sel(coord_sel),
    .mode_sel(mode_sel),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    coordinate_system_in = 2'b00;
    mode_vec = 1'b0;
    #2;
    total++;
    if ({busy, load, iter_en, done, err} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {busy, load, iter_en, done, err});
    end
    total++;
    if (shift !== 6'd0 || coord_sel !== 2'b00 || mode_sel !== 1'b0) begin
      bad++;
      $display("FAIL reset_sel got shift=%0d coord=%b mode=%b exp 0/00/0", shift, coord_sel, mode_sel);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0 || load !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got busy=%b load=%b exp 0/0", busy, load);
    end
  endtask

  task automatic test_circular;
    coordinate_system_in = 2'b01;
    mode_vec = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    coordinate_system_in = 2'b00;
    mode_vec = 1'b0;
    total++;
    if (load !== 1'b1 || busy !== 1'b1 || iter_en !== 1'b0 || shift !== 6'd0) begin
      bad++;
      $display("FAIL circ_load got load=%b busy=%b iter=%b shift=%0d exp 1/1/0/0", load, busy, iter_en, shift);
    end
    for (int i = 0; i < 16; i++) begin
      tick;
      total++;
      if (iter_en !== 1'b1 || shift !== 6'(i) || busy !== 1'b1 || done !== 1'b0 || load !== 1'b0) begin
        bad++;
        $display("FAIL circ_iter%0d got iter=%b shift=%0d busy=%b done=%b exp 1/%0d/1/0", i, iter_en, shift, busy, done, i);
      end
    end
    tick;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || iter_en !== 1'b0 || shift !== 6'd0) begin
      bad++;
      $display("FAIL circ_done got done=%b busy=%b iter=%b shift=%0d exp 1/0/0/0", done, busy, iter_en, shift);
    end
    total++;
    if (coord_sel !== 2'b01 || mode_sel !== 1'b1) begin
      bad++;
      $display("FAIL circ_latch got coord=%b mode=%b exp 01/1", coord_sel, mode_sel);
    end
    tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL circ_idle got done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  task automatic test_hyperbolic;
    int hexp [18];
    hexp = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};
    coordinate_system_in = 2'b11;
    mode_vec = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if (load !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL hyp_load got load=%b busy=%b exp 1/1", load, busy);
    end
    for (int i = 0; i < 18; i++) begin
      tick;
      total++;
      if (iter_en !== 1'b1 || shift !== 6'(hexp[i]) || done !== 1'b0) begin
        bad++;
        $display("FAIL hyp_iter%0d got iter=%b shift=%0d done=%b exp 1/%0d/0", i, iter_en, shift, done, hexp[i]);
      end
    end
    tick;
    total++;
    if (done !== 1'b1 || iter_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hyp_done got done=%b iter=%b busy=%b exp 1/0/0", done, iter_en, busy);
    end
    tick;
  endtask

  task automatic test_reserved;
    coordinate_system_in = 2'b10;
    mode_vec = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_err got err=%b busy=%b load=%b done=%b exp 1/0/0/0", err, busy, load, done);
    end
    total++;
    if (coord_sel !== 2'b11 || mode_sel !== 1'b1) begin
      bad++;
      $display("FAIL rsvd_sel got coord=%b mode=%b exp 11/1", coord_sel, mode_sel);
    end
    tick;
    total++;
    if (err !== 1'b0 || busy !== 1'b0 || load !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_after got err=%b busy=%b load=%b exp 0/0/0", err, busy, load);
    end
  endtask

  task automatic test_start_abort_idle;
    coordinate_system_in = 2'b01;
    start = 1'b1;
    abort = 1'b1;
    tick;
    total++;
    if (busy !== 1'b0 || load !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL idle_abort got busy=%b load=%b err=%b exp 0/0/0", busy, load, err);
    end
    coordinate_system_in = 2'b10;
    tick;
    total++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_abort_rsvd got err=%b busy=%b exp 0/0", err, busy);
    end
    start = 1'b0;
    abort = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    int n;
    logic seen_done;
    coordinate_system_in = 2'b01;
    mode_vec = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    total++;
    if (shift !== 6'd7 || iter_en !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got shift=%0d iter=%b exp 7/1", shift, iter_en);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || shift !== 6'd0 || iter_en !== 1'b0 || done !== 1'b0 || load !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got busy=%b shift=%0d iter=%b done=%b exp 0/0/0/0", busy, shift, iter_en, done);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet got activity=%b exp 0", seen_done);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    total++;
    if (n !== 18) begin
      bad++;
      $display("FAIL abort_rerun got done_cycle=%0d exp 18", n);
    end
    tick;
  endtask

  task automatic test_async_reset;
    logic seen;
    coordinate_system_in = 2'b01;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, load, iter_en, done, err} !== 5'b00000 || shift !== 6'd0) begin
      bad++;
      $display("FAIL async_rst got ctrl=%b shift=%0d exp 00000/0", {busy, load, iter_en, done, err}, shift);
    end
    total++;
    if (coord_sel !== 2'b00 || mode_sel !== 1'b0) begin
      bad++;
      $display("FAIL async_rst_sel got coord=%b mode=%b exp 00/0", coord_sel, mode_sel);
    end
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL async_rst_after got activity=%b exp 0", seen);
    end
  endtask

  task automatic test_input_change;
    coordinate_system_in = 2'b01;
    mode_vec = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      total++;
      if (shift !== 6'(i) || coord_sel !== 2'b01 || mode_sel !== 1'b0 || iter_en !== 1'b1) begin
        bad++;
        $display("FAIL chg_iter%0d got shift=%0d coord=%b mode=%b exp %0d/01/0", i, shift, coord_sel, mode_sel, i);
      end
      if (i == 3) begin
        coordinate_system_in = 2'b11;
        mode_vec = 1'b1;
      end
    end
    tick;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL chg_done got done=%b exp 1", done);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int n;
    coordinate_system_in = 2'b01;
    mode_vec = 1'b0;
    start = 1'b1;
    tick;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    total++;
    if (n !== 18) begin
      bad++;
      $display("FAIL b2b_done got done_cycle=%0d exp 18", n);
    end
    tick;
    total++;
    if (load !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap got load=%b busy=%b exp 0/0", load, busy);
    end
    tick;
    total++;
    if (load !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_reload got load=%b busy=%b exp 1/1", load, busy);
    end
    start = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_abort got busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  initial begin
    test_reset;
    test_circular;
    test_hyperbolic;
    test_reserved;
    test_start_abort_idle;
    test_abort;
    test_async_reset;
    test_input_change;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
